execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
REQ-003 read_data1  input  16  operand A from the decode stage register file.
REQ-004 read_data2  input  16  operand B / store data from the register file.
REQ-005 immediateValue  input  16  immediate from decode, used as-is, no extension.
REQ-006 alu_operation  input  3  ALU opcode from the control unit.
REQ-007 destination_alu_select  input  1  1 = operand B is immediateValue; 0 = operand B is read_data2.
REQ-008 mem_read, mem_write, wb  input  1 each  control bits passed through to memory/writeback.
REQ-009 src1_addr, src2_addr, dest_addr  input  3 each  register addresses of the instruction in decode.
REQ-010 in_valid  input  1  decode presents a real instruction this cycle.
REQ-011 stall  input  1  hold all outputs and flags this cycle.
REQ-012 flush  input  1  replace this cycle's capture with a bubble.
REQ-013 alu_result_out  output  16  registered ALU result.
REQ-014 store_data_out  output  16  registered operand-B register value for stores.
REQ-015 mem_read_out, mem_write_out, wb_out, valid_out  output  1 each  registered control bits.
REQ-016 dest_addr_out  output  3  registered destination address.
REQ-017 flags_out  output  3  registered {C,N,Z}.

Function
REQ-018 Opcodes: 000 pass A; 001 A+B; 010 A-B; 011 A&B; 100 A|B; 101 ~A; 110 A<<B[3:0]; 111 A>>B[3:0] (logical).
REQ-019 Latency: exactly one cycle; inputs sampled at edge N appear on outputs after edge N.
REQ-020 Results are 16-bit, wrapping modulo 2^16.
REQ-021 Z = result==0; N = result[15]; C = carry-out for ADD, borrow (A<B unsigned) for SUB, last bit shifted out for shifts, 0 for all other ops and for shift amount 0.
REQ-022 Flags update only when in_valid=1, stall=0, flush=0 and opcode != 000; otherwise flags hold.
REQ-023 stall=1, flush=0: every output register and flag holds its value.
REQ-024 flush=1, regardless of stall: valid_out, wb_out, mem_read_out and mem_write_out go to 0; data outputs go to 0; flags hold.
REQ-025 in_valid=0, no stall or flush: capture a bubble identical to REQ-024.
REQ-026 Bubbles never write the register file or memory; downstream qualifies nothing but valid_out.

Reset
REQ-027 reset=0 asynchronously forces all outputs and flags to 0, overriding stall and flush.
REQ-028 An instruction in flight when reset asserts is discarded; the first capture after release follows REQ-019.

Configuration
REQ-029 With EX_FORWARD_EN defined: if valid_out=1, wb_out=1, mem_read_out=0 and dest_addr_out==src1_addr, operand A uses alu_result_out.
REQ-030 With EX_FORWARD_EN defined: the same condition on src2_addr replaces read_data2 with alu_result_out for both operand B (when select=0) and store data.
REQ-031 Without EX_FORWARD_EN: operands always come from read_data1, read_data2 and immediateValue, with no forwarding logic.

Verification
REQ-032 Reset: reset=0 mid-stream -> all outputs 0 within the same cycle, before the next clock edge.
REQ-033 ADD overflow: A=16'hFFFF, B=16'h0001, op=001 -> result 16'h0000, flags {C,N,Z}=3'b101.
REQ-034 SUB with immediate: A=16'h0003, imm=16'h0005, select=1, op=010 -> result 16'hFFFE, flags {C,N,Z}=3'b110.
REQ-035 Stall then flush: stall=1 for 2 cycles -> outputs unchanged; then flush=1 -> valid_out=0, wb_out=0, flags unchanged.
REQ-036 Back-to-back dependency: ADD r1=5+3, then ADD r2=r1+1 with stale read_data1=0 -> with EX_FORWARD_EN the second result is 9; without it the second result is 1.
REQ-037 Shift: A=16'h8001, B=16'h0001, op=110 -> result 16'h0002, C=1; same A with op=111 -> result 16'h4000, C=1.

Source files
------------

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//   Single-cycle execute stage of a 16-bit pipeline. It selects the ALU operands,
//   computes the result and the {C,N,Z} flags, and registers the result together
//   with the store data and the memory/writeback control bits for the next stage.
//
//   Optional feature macro: EX_FORWARD_EN
//     When it is defined, the registered result of the previous instruction is
//     forwarded into operand A and/or register operand B (and store data). This
//     happens when that result is valid, will be written back, is not a load,
//     and targets the source register being read.
//
// Ports
//   clk, reset                   clock, asynchronous active-low reset
//   read_data1 / read_data2      register file operands A and B (B = store data)
//   immediateValue               immediate used unextended as operand B when
//                                destination_alu_select = 1
//   alu_operation                3-bit ALU opcode
//   mem_read/mem_write/wb        control bits passed to memory / writeback
//   src1_addr/src2_addr          source register addresses (forwarding compare)
//   dest_addr                    destination register address
//   in_valid, stall, flush       pipeline handshake
//   alu_result_out, store_data_out, mem_read_out, mem_write_out, wb_out,
//   valid_out, dest_addr_out, flags_out ({C,N,Z})   registered stage outputs
// -----------------------------------------------------------------------------
module execute_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] read_data1,
  input  logic [15:0] read_data2,
  input  logic [15:0] immediateValue,
  input  logic [2:0]  alu_operation,
  input  logic        destination_alu_select,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        wb,
  input  logic [2:0]  src1_addr,
  input  logic [2:0]  src2_addr,
  input  logic [2:0]  dest_addr,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] alu_result_out,
  output logic [15:0] store_data_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        wb_out,
  output logic        valid_out,
  output logic [2:0]  dest_addr_out,
  output logic [2:0]  flags_out
);

  logic [15:0] alu_result_q, alu_result_d;
  logic [15:0] store_data_q, store_data_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        wb_q, wb_d;
  logic        valid_q, valid_d;
  logic [2:0]  dest_addr_q, dest_addr_d;
  logic [2:0]  flags_q, flags_d;

  logic [15:0] op_a_s;
  logic [15:0] rd2_s;
  logic [15:0] op_b_s;
  logic [15:0] result_s;
  logic        carry_s;
  logic [16:0] sum_s;
  logic [3:0]  shamt_s;
  logic [3:0]  shl_idx_s;

`ifdef EX_FORWARD_EN
  logic        fwd_ok_s;
  // The previous result may be forwarded only if it is a real, non-load writeback.
  assign fwd_ok_s = valid_q & wb_q & ~mem_read_q;
`else
  logic        unused_addr_s;
  assign unused_addr_s = ^{src1_addr, src2_addr};
`endif

  // Operand selection (with optional forwarding from the registered result).
  always_comb begin
    op_a_s = read_data1;
    rd2_s  = read_data2;
`ifdef EX_FORWARD_EN
    if (fwd_ok_s && (dest_addr_q == src1_addr)) begin
      op_a_s = alu_result_q;
    end else begin
      op_a_s = read_data1;
    end
    if (fwd_ok_s && (dest_addr_q == src2_addr)) begin
      rd2_s = alu_result_q;
    end else begin
      rd2_s = read_data2;
    end
`endif
    if (destination_alu_select) begin
      op_b_s = immediateValue;
    end else begin
      op_b_s = rd2_s;
    end
  end

  assign sum_s     = {1'b0, op_a_s} + {1'b0, op_b_s};
  assign shamt_s   = op_b_s[3:0];
  // 16 - shamt modulo 16: the index of the last bit shifted out on a left shift.
  assign shl_idx_s = 4'd0 - shamt_s;

  // ALU result and carry/borrow/shift-out bit.
  always_comb begin
    result_s = op_a_s;
    carry_s  = 1'b0;
    case (alu_operation)
      3'b000: begin result_s = op_a_s;            carry_s = 1'b0;              end
      3'b001: begin result_s = sum_s[15:0];       carry_s = sum_s[16];         end
      3'b010: begin result_s = op_a_s - op_b_s;   carry_s = (op_a_s < op_b_s); end
      3'b011: begin result_s = op_a_s & op_b_s;   carry_s = 1'b0;              end
      3'b100: begin result_s = op_a_s | op_b_s;   carry_s = 1'b0;              end
      3'b101: begin result_s = ~op_a_s;           carry_s = 1'b0;              end
      3'b110: begin
        result_s = op_a_s << shamt_s;
        if (shamt_s != 4'd0) begin
          carry_s = op_a_s[shl_idx_s];
        end else begin
          carry_s = 1'b0;
        end
      end
      3'b111: begin
        result_s = op_a_s >> shamt_s;
        if (shamt_s != 4'd0) begin
          carry_s = op_a_s[shamt_s - 4'd1];
        end else begin
          carry_s = 1'b0;
        end
      end
      default: begin result_s = op_a_s; carry_s = 1'b0; end
    endcase
  end

  // Next-state selection: hold on stall, bubble on flush/invalid, else capture.
  always_comb begin
    alu_result_d = alu_result_q;
    store_data_d = store_data_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    wb_d         = wb_q;
    valid_d      = valid_q;
    dest_addr_d  = dest_addr_q;
    flags_d      = flags_q;
    if (stall && !flush) begin
      flags_d = flags_q;
    end else if (flush || !in_valid) begin
      alu_result_d = 16'h0000;
      store_data_d = 16'h0000;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      wb_d         = 1'b0;
      valid_d      = 1'b0;
      dest_addr_d  = 3'b000;
    end else begin
      alu_result_d = result_s;
      store_data_d = rd2_s;
      mem_read_d   = mem_read;
      mem_write_d  = mem_write;
      wb_d         = wb;
      valid_d      = 1'b1;
      dest_addr_d  = dest_addr;
      // A plain pass does not disturb the flags.
      if (alu_operation != 3'b000) begin
        flags_d = {carry_s, result_s[15], (result_s == 16'h0000)};
      end else begin
        flags_d = flags_q;
      end
    end
  end

  // Pipeline register with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_result_q <= 16'h0000;
      store_data_q <= 16'h0000;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      wb_q         <= 1'b0;
      valid_q      <= 1'b0;
      dest_addr_q  <= 3'b000;
      flags_q      <= 3'b000;
    end else begin
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      wb_q         <= wb_d;
      valid_q      <= valid_d;
      dest_addr_q  <= dest_addr_d;
      flags_q      <= flags_d;
    end
  end

  assign alu_result_out = alu_result_q;
  assign store_data_out = store_data_q;
  assign mem_read_out   = mem_read_q;
  assign mem_write_out  = mem_write_q;
  assign wb_out         = wb_q;
  assign valid_out      = valid_q;
  assign dest_addr_out  = dest_addr_q;
  assign flags_out      = flags_q;

endmodule

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
//   Self-checking bench for execute_stage: a table of directed ALU vectors,
//   hand-written reset / stall / flush / dependency sequences, and a random
//   phase, all compared against an arithmetic reference model of the stage.
//   Honours EX_FORWARD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] read_data1, read_data2, immediateValue;
  logic [2:0]  alu_operation;
  logic        destination_alu_select;
  logic        mem_read, mem_write, wb;
  logic [2:0]  src1_addr, src2_addr, dest_addr;
  logic        in_valid, stall, flush;
  logic [15:0] alu_result_out, store_data_out;
  logic        mem_read_out, mem_write_out, wb_out, valid_out;
  logic [2:0]  dest_addr_out, flags_out;

  int total = 0;
  int bad   = 0;

  execute_stage dut (
    .clk(clk), .reset(reset),
    .read_data1(read_data1), .read_data2(read_data2), .immediateValue(immediateValue),
    .alu_operation(alu_operation), .destination_alu_select(destination_alu_select),
    .mem_read(mem_read), .mem_write(mem_write), .wb(wb),
    .src1_addr(src1_addr), .src2_addr(src2_addr), .dest_addr(dest_addr),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .wb_out(wb_out), .valid_out(valid_out),
    .dest_addr_out(dest_addr_out), .flags_out(flags_out)
  );

  always #5 clk = ~clk;

  // Reference model state: what the stage outputs should currently show.
  logic [15:0] m_res, m_store;
  logic        m_mr, m_mw, m_wb, m_valid;
  logic [2:0]  m_dest, m_flags;

  typedef struct {
    logic [15:0] a;
    logic [15:0] rd2;
    logic [15:0] imm;
    logic        sel;
    logic [2:0]  op;
    logic [15:0] res;
    logic [2:0]  fl;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".result"}, alu_result_out, m_res);
    check({tag, ".store"},  store_data_out, m_store);
    check({tag, ".mr"},     {15'd0, mem_read_out},  {15'd0, m_mr});
    check({tag, ".mw"},     {15'd0, mem_write_out}, {15'd0, m_mw});
    check({tag, ".wb"},     {15'd0, wb_out},        {15'd0, m_wb});
    check({tag, ".valid"},  {15'd0, valid_out},     {15'd0, m_valid});
    check({tag, ".dest"},   {13'd0, dest_addr_out}, {13'd0, m_dest});
    check({tag, ".flags"},  {13'd0, flags_out},     {13'd0, m_flags});
  endtask

  task automatic model_clear();
    m_res = 16'h0; m_store = 16'h0; m_mr = 1'b0; m_mw = 1'b0;
    m_wb = 1'b0; m_valid = 1'b0; m_dest = 3'd0; m_flags = 3'd0;
  endtask

  // Arithmetic model of one clock edge, evaluated on the inputs about to be sampled.
  task automatic model_edge();
    int a, b, r, s, rd2;
    logic c;
    if (stall && !flush) return;
    if (flush || !in_valid) begin
      m_res = 16'h0; m_store = 16'h0; m_mr = 1'b0; m_mw = 1'b0;
      m_wb = 1'b0; m_valid = 1'b0; m_dest = 3'd0;
      return;
    end
    a   = int'(read_data1);
    rd2 = int'(read_data2);
`ifdef EX_FORWARD_EN
    if (m_valid && m_wb && !m_mr && m_dest == src1_addr) a = int'(m_res);
    if (m_valid && m_wb && !m_mr && m_dest == src2_addr) rd2 = int'(m_res);
`endif
    b = destination_alu_select ? int'(immediateValue) : rd2;
    s = b % 16;
    c = 1'b0;
    case (alu_operation)
      3'd0: r = a;
      3'd1: begin r = a + b; c = (r > 65535); end
      3'd2: begin r = a - b; c = (a < b); end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = ~a;
      3'd6: begin r = a << s; c = (s != 0) && (((r >> 16) & 1) == 1); end
      3'd7: begin r = a >> s; c = (s != 0) && (((a >> (s - 1)) & 1) == 1); end
      default: r = a;
    endcase
    r = r & 65535;
    m_res   = r[15:0];
    m_store = rd2[15:0];
    m_mr    = mem_read;
    m_mw    = mem_write;
    m_wb    = wb;
    m_valid = 1'b1;
    m_dest  = dest_addr;
    if (alu_operation != 3'd0) m_flags = {c, r[15], (r == 0)};
  endtask

  // Apply current inputs over one edge and compare everything against the model.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_instr(input logic [15:0] a, input logic [15:0] rd2, input logic [15:0] imm,
                           input logic sel, input logic [2:0] op);
    read_data1 = a; read_data2 = rd2; immediateValue = imm;
    destination_alu_select = sel; alu_operation = op;
    in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
  endtask

  logic [15:0] sv_res;
  logic [2:0]  sv_flags;
  logic [2:0]  sv_dest;

  initial begin
    tbl[0]  = '{16'hFFFF, 16'h0001, 16'h0000, 1'b0, 3'b001, 16'h0000, 3'b101};
    tbl[1]  = '{16'h0003, 16'h1234, 16'h0005, 1'b1, 3'b010, 16'hFFFE, 3'b110};
    tbl[2]  = '{16'h8001, 16'h0001, 16'h0000, 1'b0, 3'b110, 16'h0002, 3'b100};
    tbl[3]  = '{16'h8001, 16'h0001, 16'h0000, 1'b0, 3'b111, 16'h4000, 3'b100};
    tbl[4]  = '{16'hF0F0, 16'h0FF0, 16'h0000, 1'b0, 3'b011, 16'h00F0, 3'b000};
    tbl[5]  = '{16'hF000, 16'h000F, 16'h0000, 1'b0, 3'b100, 16'hF00F, 3'b010};
    tbl[6]  = '{16'hFFFF, 16'h5555, 16'h0000, 1'b0, 3'b101, 16'h0000, 3'b001};
    tbl[7]  = '{16'h1234, 16'h0000, 16'h0000, 1'b0, 3'b000, 16'h1234, 3'b001};
    tbl[8]  = '{16'h0005, 16'h0005, 16'h0000, 1'b0, 3'b010, 16'h0000, 3'b001};
    tbl[9]  = '{16'h1234, 16'h0010, 16'h0000, 1'b0, 3'b110, 16'h1234, 3'b000};
    tbl[10] = '{16'h8000, 16'h8000, 16'h0000, 1'b0, 3'b001, 16'h0000, 3'b101};
    tbl[11] = '{16'h0001, 16'h0000, 16'h0001, 1'b1, 3'b111, 16'h0000, 3'b101};
    tbl[12] = '{16'h4000, 16'h0001, 16'h0000, 1'b0, 3'b110, 16'h8000, 3'b010};

    reset = 1'b0;
    set_instr(16'h0, 16'h0, 16'h0, 1'b0, 3'd0);
    mem_read = 1'b0; mem_write = 1'b0; wb = 1'b0;
    src1_addr = 3'd0; src2_addr = 3'd0; dest_addr = 3'd0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset_state");
    reset = 1'b1;

    // Directed ALU table; wb=0 keeps forwarding out of the picture.
    for (int i = 0; i < 13; i++) begin
      set_instr(tbl[i].a, tbl[i].rd2, tbl[i].imm, tbl[i].sel, tbl[i].op);
      mem_read = 1'b0; mem_write = 1'b0; wb = 1'b0;
      src1_addr = 3'd1; src2_addr = 3'd2; dest_addr = 3'(i);
      step($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.res_const", i), alu_result_out, tbl[i].res);
      check($sformatf("tbl%0d.flags_const", i), {13'd0, flags_out}, {13'd0, tbl[i].fl});
      check($sformatf("tbl%0d.store_const", i), store_data_out, tbl[i].rd2);
    end

    // Bubble from in_valid=0: controls and data cleared, flags kept.
    sv_flags = m_flags;
    in_valid = 1'b0; wb = 1'b1; mem_write = 1'b1;
    step("bubble");
    check("bubble.valid", {15'd0, valid_out}, 16'd0);
    check("bubble.flags_kept", {13'd0, flags_out}, {13'd0, sv_flags});

    // Stall for two cycles, then flush.
    set_instr(16'h0003, 16'h0000, 16'h0005, 1'b1, 3'b010);
    wb = 1'b1; mem_write = 1'b0; dest_addr = 3'd5; src1_addr = 3'd0; src2_addr = 3'd0;
    step("pre_stall");
    sv_res = m_res; sv_flags = m_flags; sv_dest = m_dest;
    for (int k = 0; k < 2; k++) begin
      set_instr(16'h7777, 16'h1111, 16'h2222, 1'b0, 3'b001);
      stall = 1'b1; dest_addr = 3'd6;
      step($sformatf("stall%0d", k));
      check($sformatf("stall%0d.res_held", k), alu_result_out, sv_res);
      check($sformatf("stall%0d.flags_held", k), {13'd0, flags_out}, {13'd0, sv_flags});
      check($sformatf("stall%0d.dest_held", k), {13'd0, dest_addr_out}, {13'd0, sv_dest});
    end
    flush = 1'b1;
    step("flush");
    check("flush.valid", {15'd0, valid_out}, 16'd0);
    check("flush.wb", {15'd0, wb_out}, 16'd0);
    check("flush.flags_held", {13'd0, flags_out}, {13'd0, sv_flags});

    // Back-to-back dependency: r1 = 5+3, then r2 = r1 + 1 with stale operand A.
    set_instr(16'd5, 16'd3, 16'd0, 1'b0, 3'b001);
    wb = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    dest_addr = 3'd1; src1_addr = 3'd4; src2_addr = 3'd5;
    step("dep1");
    check("dep1.res_const", alu_result_out, 16'd8);
    set_instr(16'd0, 16'd0, 16'd1, 1'b1, 3'b001);
    dest_addr = 3'd2; src1_addr = 3'd1; src2_addr = 3'd3;
    step("dep2");
`ifdef EX_FORWARD_EN
    check("dep2.res_const", alu_result_out, 16'd9);
`else
    check("dep2.res_const", alu_result_out, 16'd1);
`endif

    // Reset asserted mid-stream, away from the clock edge.
    set_instr(16'h1234, 16'h4321, 16'h0000, 1'b0, 3'b100);
    step("pre_reset");
    set_instr(16'hFFFF, 16'h0001, 16'h0000, 1'b0, 3'b001);
    stall = 1'b1; flush = 1'b1;
    reset = 1'b0;
    #2;
    model_clear();
    check_all("async_reset");
    @(posedge clk);
    #1;
    check_all("reset_held");
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    step("first_after_reset");
    check("first_after_reset.res_const", alu_result_out, 16'h0000);
    check("first_after_reset.flags_const", {13'd0, flags_out}, {13'd0, 3'b101});

    // Random stream against the model.
    for (int n = 0; n < 400; n++) begin
      read_data1 = 16'($urandom);
      read_data2 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      immediateValue = 16'($urandom);
      destination_alu_select = 1'($urandom);
      alu_operation = 3'($urandom);
      mem_read = ($urandom_range(0, 3) == 0);
      mem_write = 1'($urandom);
      wb = ($urandom_range(0, 3) != 0);
      src1_addr = 3'($urandom); src2_addr = 3'($urandom); dest_addr = 3'($urandom);
      in_valid = ($urandom_range(0, 5) != 0);
      stall = ($urandom_range(0, 6) == 0);
      flush = ($urandom_range(0, 8) == 0);
      step($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
